// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clk_div_bank channel divider bank.
package clk_div_pkg;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int DIV_W = 16;
  typedef logic [DIV_W-1:0] div_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divide ratio, mode tracking,
// and registered out/tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  output logic             out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             mode_q, mode_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             event_w;

  assign event_w = (div_q != '0) && (cnt_q == div_q - DIV_ONE);

  always_comb begin
    shd_d  = ld ? ld_div : shd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    mode_d = mode_q;
    out_d  = out_q;
    tick_d = 1'b0;
    if (!en) begin
      // mode_q follows mode while idle so re-enable never looks like a mode change
      cnt_d  = '0;
      out_d  = 1'b0;
      div_d  = shd_d;
      mode_d = mode;
    end else if (mode != mode_q) begin
      cnt_d  = '0;
      out_d  = 1'b0;
      mode_d = mode;
    end else if (div_q == '0) begin
      // D=0 never produces an event, so a stalled channel picks up a new ratio at once
      cnt_d = '0;
      out_d = 1'b0;
      div_d = shd_d;
    end else if (event_w) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      div_d  = shd_d;
      out_d  = (mode_q == MODE_PULSE) ? 1'b1 : ((shd_d != '0) && !out_q);
    end else begin
      cnt_d = cnt_q + DIV_ONE;
      out_d = (mode_q == MODE_PULSE) ? 1'b0 : out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= DIV_RST;
      shd_q  <= DIV_RST;
      mode_q <= MODE_SQUARE;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      mode_q <= mode_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable clock-enable/divider channels with a
// shared load port decoded by channel index.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic             ld_valid,
  input  logic [CH_W-1:0]  ld_ch,
  input  logic [CNT_W-1:0] ld_div,
  output logic [NCH-1:0]   out,
  output logic [NCH-1:0]   tick
);

  logic ld_in_range;
  assign ld_in_range = ({1'b0, ld_ch} < (CH_W+1)'(NCH));

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic ld_w;
    assign ld_w = ld_valid && ld_in_range && (ld_ch == CH_W'(i));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en[i]),
      .mode   (mode[i]),
      .ld     (ld_w),
      .ld_div (ld_div),
      .out    (out[i]),
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: a 4-channel 16-bit instance plus a 3-channel 8-bit
// instance, both checked every cycle against an elapsed-edge reference model.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A: NCH=4, CNT_W=16 ----------------
  logic [3:0] en, mode, out, tick;
  logic       ld_valid;
  logic [1:0] ld_ch;
  div_t       ld_div;

  clk_div_bank #(.NCH(4), .CNT_W(16), .DEFAULT_DIV(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ld_valid(ld_valid),
    .ld_ch(ld_ch), .ld_div(ld_div), .out(out), .tick(tick)
  );

  // ---------------- DUT B: NCH=3, CNT_W=8 ----------------
  logic [2:0] en3, mode3, out3, tick3;
  logic       ld3_valid;
  logic [1:0] ld3_ch;
  logic [7:0] ld3_div;

  clk_div_bank #(.NCH(3), .CNT_W(8), .DEFAULT_DIV(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .ld_valid(ld3_valid),
    .ld_ch(ld3_ch), .ld_div(ld3_div), .out(out3), .tick(tick3)
  );

  logic [6:0] obs_out, obs_tick;
  assign obs_out  = {out3, out};
  assign obs_tick = {tick3, tick};

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- reference model ----------------
  // Channels 0..3 belong to DUT A, 4..6 to DUT B. A period is D enabled edges;
  // the edge that completes it is the event.
  int m_act[7], m_shd[7], m_el[7];
  bit m_mode[7], m_out[7], m_tick[7];
  bit me, mm, ml;
  int mnd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 7; k++) begin
        m_act[k] = 2; m_shd[k] = 2; m_el[k] = 0;
        m_mode[k] = 0; m_out[k] = 0; m_tick[k] = 0;
      end
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (k < 4) begin
          me = en[k]; mm = mode[k]; mnd = int'(ld_div);
          ml = ld_valid && (int'(ld_ch) == k);
        end else begin
          me = en3[k-4]; mm = mode3[k-4]; mnd = int'(ld3_div);
          ml = ld3_valid && (int'(ld3_ch) == k - 4);
        end
        if (ml) m_shd[k] = mnd;
        m_tick[k] = 0;
        if (!me) begin
          m_el[k] = 0; m_out[k] = 0; m_act[k] = m_shd[k]; m_mode[k] = mm;
        end else if (mm != m_mode[k]) begin
          m_el[k] = 0; m_out[k] = 0; m_mode[k] = mm;
        end else if (m_act[k] == 0) begin
          m_el[k] = 0; m_out[k] = 0; m_act[k] = m_shd[k];
        end else begin
          m_el[k] = m_el[k] + 1;
          if (m_el[k] == m_act[k]) begin
            m_el[k] = 0; m_tick[k] = 1; m_act[k] = m_shd[k];
            if (mm == MODE_PULSE) m_out[k] = 1;
            else m_out[k] = (m_act[k] == 0) ? 1'b0 : !m_out[k];
          end else if (mm == MODE_PULSE) begin
            m_out[k] = 0;
          end
        end
      end
    end
  end

  logic [6:0] exp_out, exp_tick;
  always_comb begin
    exp_out  = '0;
    exp_tick = '0;
    for (int k = 0; k < 7; k++) begin
      exp_out[k]  = m_out[k];
      exp_tick[k] = m_tick[k];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ld(input logic [1:0] ch, input int d);
    ld_valid = 1'b1; ld_ch = ch; ld_div = div_t'(d);
  endtask

  task automatic set_ld3(input logic [1:0] ch, input int d);
    ld3_valid = 1'b1; ld3_ch = ch; ld3_div = 8'(d);
  endtask

  task automatic clr_ld();
    ld_valid = 1'b0; ld3_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs_out !== 7'b0 || obs_tick !== 7'b0)
      $display("FAIL reset_hold: out=%b tick=%b want 0/0", obs_out, obs_tick);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_square_default();
    int rise_at = 0;
    en[0] = 1'b1; mode[0] = MODE_SQUARE;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL square_default c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (rise_at == 0 && out[0]) rise_at = i;
    end
    n_chk++;
    if (rise_at !== 2) $display("FAIL square_first_rise: edge %0d want 2", rise_at);
    else n_pass++;
    en[0] = 1'b0;
  endtask

  task automatic test_pulse_load();
    int first = 0;
    mode[1] = MODE_PULSE;
    set_ld(2'd1, 5);
    @(negedge clk);
    clr_ld();
    en[1] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick || out[1] !== tick[1])
        $display("FAIL pulse_d5 c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (first == 0 && tick[1]) first = i;
    end
    n_chk++;
    if (first !== 5) $display("FAIL pulse_first: edge %0d want 5", first);
    else n_pass++;
    en[1] = 1'b0;
  endtask

  task automatic test_load_midperiod();
    int t1 = 0, t2 = 0;
    bit found = 0;
    set_ld(2'd0, 4);
    en[2] = 1'b1; mode[2] = MODE_SQUARE;
    en[3] = 1'b1; mode[3] = MODE_PULSE;
    @(negedge clk);
    clr_ld();
    en[0] = 1'b1; mode[0] = MODE_SQUARE;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL midload_wait c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (m_el[0] == 1) found = 1;
    end
    n_chk++;
    if (!found) $display("FAIL midload_sync: cnt=1 not reached, got elapsed %0d", m_el[0]);
    else n_pass++;
    set_ld(2'd0, 3);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) clr_ld();
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL midload c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (tick[0]) begin
        if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
    end
    n_chk++;
    if (t1 !== 3 || t2 !== 6) $display("FAIL midload_gaps: ticks at %0d,%0d want 3,6", t1, t2);
    else n_pass++;
  endtask

  task automatic test_event_bypass();
    int t1 = 0, t2 = 0;
    bit found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL bypass_wait c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (m_el[0] == 2) found = 1;
    end
    n_chk++;
    if (!found) $display("FAIL bypass_sync: event edge not reached, elapsed %0d", m_el[0]);
    else n_pass++;
    set_ld(2'd0, 6);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) clr_ld();
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL bypass c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (tick[0]) begin
        if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
    end
    n_chk++;
    if (t1 !== 1 || t2 !== 7) $display("FAIL bypass_gaps: ticks at %0d,%0d want 1,7", t1, t2);
    else n_pass++;
    // out-of-range index on the 3-channel instance must not touch any channel
    en3 = 3'b111; mode3 = 3'b010;
    set_ld3(2'd3, 1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL ld_out_of_range c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
    end
    clr_ld();
    en3 = 3'b000;
  endtask

  task automatic test_d0_disable_mode();
    bit quiet = 1;
    int first = 0;
    set_ld(2'd0, 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) clr_ld();
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL d0 c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (i > 8 && (out[0] || tick[0])) quiet = 0;
    end
    n_chk++;
    if (!quiet) $display("FAIL d0_quiet: ch0 active after D=0, want out/tick 0");
    else n_pass++;
    en[2] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (out[2] !== 1'b0 || tick[2] !== 1'b0 || obs_out !== exp_out)
      $display("FAIL disable: out2=%b tick2=%b want 0/0", out[2], tick[2]);
    else n_pass++;
    set_ld(2'd3, 4);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) clr_ld();
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL mode_prep c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
    end
    mode[3] = MODE_SQUARE;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL mode_change c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (first == 0 && tick[3]) first = i;
    end
    n_chk++;
    if (first !== 5) $display("FAIL mode_restart: first tick edge %0d want 5", first);
    else n_pass++;
    en = 4'b0;
  endtask

  task automatic test_max_div();
    int rise_at = 0;
    set_ld3(2'd0, 255);
    @(negedge clk);
    clr_ld();
    en3 = 3'b001; mode3 = 3'b000;
    for (int i = 1; i <= 520; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL max_div c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (rise_at == 0 && out3[0]) rise_at = i;
    end
    n_chk++;
    if (rise_at !== 255) $display("FAIL max_div_rise: edge %0d want 255", rise_at);
    else n_pass++;
    en3 = 3'b000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL random c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(15) == 0) en[j] = ~en[j];
        if ($urandom_range(31) == 0) mode[j] = ~mode[j];
      end
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(15) == 0) en3[j] = ~en3[j];
        if ($urandom_range(31) == 0) mode3[j] = ~mode3[j];
      end
      ld_valid  = ($urandom_range(3) == 0);
      ld_ch     = 2'($urandom_range(3));
      ld_div    = div_t'($urandom_range(7));
      ld3_valid = ($urandom_range(3) == 0);
      ld3_ch    = 2'($urandom_range(3));
      ld3_div   = 8'($urandom_range(7));
    end
    clr_ld();
  endtask

  task automatic test_async_reset();
    en = 4'hF; mode = 4'h0; en3 = 3'b000;
    set_ld(2'd0, 3);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) clr_ld();
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL prereset c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs_out !== 7'b0 || obs_tick !== 7'b0)
      $display("FAIL async_reset: out=%b tick=%b want 0/0", obs_out, obs_tick);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_out !== exp_out || obs_tick !== exp_tick)
        $display("FAIL postreset c%0d: out=%b tick=%b want %b/%b", i, obs_out, obs_tick, exp_out, exp_tick);
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if (out !== 4'hF) $display("FAIL postreset_default: out=%b want 1111", out);
        else n_pass++;
      end
    end
  endtask

  initial begin
    en = '0; mode = '0; en3 = '0; mode3 = '0;
    ld_valid = 1'b0; ld_ch = '0; ld_div = '0;
    ld3_valid = 1'b0; ld3_ch = '0; ld3_div = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_square_default();
    test_pulse_load();
    test_load_midperiod();
    test_event_bypass();
    test_d0_disable_mode();
    test_max_div();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
